alu_op_seq: RTL
===============

# alu_op_seq

Micro-sequencer that sits directly upstream of the ALU in the 8-bit CPU datapath. It accepts one 16-bit instruction at a time over a valid/ready handshake and reads operands from a 4×8-bit register file it owns. It drives the ALU's one-hot operation strobes and operands, waits out the ALU latency, and writes the result and flags back. Non-ALU instructions (NOP, MOV, LDI) complete without touching the ALU.

## Interface
- ALU_LAT, 1, cycles from the ALU strobe edge until `alu_b` and the flags are valid (1..7)
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  reset, synchronous and active-low
- ins_valid  in  1  instruction offered
- ins_data  in  16  instruction word: [15:13] op, [12:11] rd, [10:9] rs, [8] reserved (ignored), [7:0] imm
- ins_ready  out  1  sequencer idle; the instruction is accepted on a clock edge where `ins_valid & ins_ready`
- add, sub, inc, dec  out  1 each  one-hot ALU strobes
- input_x  out  8  ALU operand X = R[rd]
- input_y  out  8  ALU operand Y = R[rs] for ADD/SUB, 8'h00 for INC/DEC
- alu_b  in  8  ALU result
- CF, AF, ZF, SF, OF  in  1 each  ALU flags
- flag_c, flag_a, flag_z, flag_s, flag_o  out  1 each  architectural flags, registered
- done  out  1  one-cycle pulse when an instruction retires
- err  out  1  valid with `done`; 1 = illegal opcode
- dbg_sel  in  2  register-file read select
- dbg_data  out  8  R[dbg_sel], combinational read of the register state

## Operation
- Opcodes:
  - 000 NOP
  - 001 ADD: rd = rd + rs
  - 010 SUB: rd = rd − rs
  - 011 INC: rd = rd + 1
  - 100 DEC: rd = rd − 1
  - 101 MOV: rd = rs
  - 110 LDI: rd = imm
  - 111 illegal
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: `ins_ready` = 1.
  - On acceptance of an ALU op (001–100): capture the op; register `input_x` and `input_y`; go to ISSUE.
  - On acceptance of MOV/LDI: write R[rd] on the acceptance edge; go to DONE.
  - On acceptance of NOP or illegal: no state change; go to DONE. For illegal, `err` = 1 in DONE.
- ISSUE (exactly 1 cycle): the matching strobe is high and the other three are low. Next state is WAIT; load `wcnt` = ALU_LAT−1.
- WAIT: stay until `wcnt` = 0, decrementing each cycle.
  - On the edge leaving WAIT: R[rd] ← `alu_b`; `flag_*` ← CF/AF/ZF/SF/OF; go to DONE.
- DONE (1 cycle): `done` = 1; `err` as decided; next state is IDLE.
- Flags change only on ALU-op writeback. NOP, MOV, LDI and illegal leave them unchanged.
- `input_x` and `input_y` are held stable from ISSUE through the last WAIT cycle.
- rd == rs is legal. ADD R1,R1 drives X = Y = R[1].
- The reserved bit [8] and the `imm` field of non-LDI ops are ignored.

## Timing
- Reset (`rst_n` = 0 at a rising edge), regardless of state:
  - state = IDLE; R0..R3 = 0; all `flag_*` = 0; strobes = 0; `input_x` = `input_y` = 0; `done` = `err` = 0.
  - `ins_ready` = 1 from the first cycle after reset deasserts.
- Reset mid-instruction aborts it. There is no writeback, and ALU outputs arriving afterwards are ignored.
- ALU op accepted at the end of cycle T:
  - ISSUE in T+1.
  - WAIT in T+2 .. T+1+ALU_LAT; writeback at the end of T+1+ALU_LAT.
  - DONE in T+2+ALU_LAT.
  - `ins_ready` = 1 again in T+3+ALU_LAT.
  - Total with ALU_LAT = 1: 3 busy cycles.
- MOV/LDI/NOP/illegal accepted at the end of T: DONE in T+1, IDLE in T+2. The register write is visible on `dbg_data` from T+1.
- `ins_valid` while `ins_ready` = 0: not accepted. Upstream holds `ins_data`, and no state is disturbed.
- The ALU strobes are never asserted outside ISSUE and never two at once.
- If `dbg_sel` selects a register written on the current edge, `dbg_data` shows the old value before the edge and the new value after it.
- Back-to-back: a new instruction can be accepted in the IDLE cycle that immediately follows DONE.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles, then release → all R = 0, all flags 0, `ins_ready` = 1, strobes 0, `done` = 0.
- LDI R0,0xF5; LDI R1,0xF5; ADD R0,R1 (ALU_LAT = 1):
  - `add` is high for exactly 1 cycle in T+1, with X = Y = 0xF5.
  - `done` pulses in T+3 and R0 = 0xEA.
  - Flags = c1 z0 s1 o0 (a from the ALU model).
- With R2 = 0x7F: INC R2 → `inc` strobe, Y = 0x00, R2 = 0x80, `flag_o` = 1, `flag_s` = 1. Then DEC R3 (R3 = 0) → R3 = 0xFF, `flag_s` = 1.
- Handshake: hold `ins_valid` = 1 with SUB R0,R0 followed by a second instruction →
  - `ins_ready` is low for 3 cycles.
  - The second instruction is accepted only after DONE.
  - R0 = 0x00, `flag_z` = 1.
- Illegal op 3'b111 → `done` = 1 and `err` = 1 in T+1. Registers and flags are unchanged, and no strobe fires.
- Assert `rst_n` = 0 during WAIT of ADD → the destination register is not written, the state returns to IDLE, and the flags are 0.

Source files
------------

// File: rtl/alu_op_seq.sv
// ---------------------------------------------------------------------------
// alu_op_seq
//
// Micro-sequencer in front of the 8-bit ALU. It accepts one 16-bit
// instruction at a time over a valid/ready handshake and owns a 4 x 8-bit
// register file. ALU operations (ADD/SUB/INC/DEC) are issued to the external
// ALU as a one-cycle one-hot strobe. The sequencer then waits ALU_LAT cycles
// and writes the result and flags back. NOP, MOV, LDI and illegal opcodes
// retire without touching the ALU.
//
// Parameters
//   ALU_LAT   cycles from the strobe edge until alu_b and flags are valid (1..7)
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   ins_valid, ins_data[15:0]   instruction offer:
//                               [15:13] op, [12:11] rd, [10:9] rs,
//                               [8] reserved, [7:0] imm
//   ins_ready                   high while idle; accept on valid & ready
//   add, sub, inc, dec          one-hot ALU strobes, high only in ISSUE
//   input_x, input_y [7:0]      ALU operands (R[rd], and R[rs] or 0)
//   alu_b [7:0], CF..OF         ALU result and flags
//   flag_c..flag_o              architectural flags, registered
//   done, err                   retire pulse; err marks an illegal opcode
//   dbg_sel [1:0], dbg_data     combinational register-file read port
// ---------------------------------------------------------------------------
module alu_op_seq #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ins_valid,
    input  logic [15:0] ins_data,
    output logic        ins_ready,
    output logic        add,
    output logic        sub,
    output logic        inc,
    output logic        dec,
    output logic [7:0]  input_x,
    output logic [7:0]  input_y,
    input  logic [7:0]  alu_b,
    input  logic        CF,
    input  logic        AF,
    input  logic        ZF,
    input  logic        SF,
    input  logic        OF,
    output logic        flag_c,
    output logic        flag_a,
    output logic        flag_z,
    output logic        flag_s,
    output logic        flag_o,
    output logic        done,
    output logic        err,
    input  logic [1:0]  dbg_sel,
    output logic [7:0]  dbg_data
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_INC = 3'b011;
    localparam logic [2:0] OP_DEC = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  regs [4];
    logic [2:0]  op_q;
    logic [1:0]  rd_q;
    logic [2:0]  wcnt;
    logic        err_q;

    // Instruction field decode of the word currently offered.
    logic [2:0]  op_in;
    logic [1:0]  rd_in;
    logic [1:0]  rs_in;
    logic [7:0]  imm_in;
    logic        accept;
    logic        is_alu_in;
    logic        unused_reserved;

    assign op_in           = ins_data[15:13];
    assign rd_in           = ins_data[12:11];
    assign rs_in           = ins_data[10:9];
    assign imm_in          = ins_data[7:0];
    assign unused_reserved = ins_data[8];
    assign accept          = ins_valid && (state == IDLE);
    assign is_alu_in       = (op_in == OP_ADD) || (op_in == OP_SUB) ||
                             (op_in == OP_INC) || (op_in == OP_DEC);

    assign dbg_data = regs[dbg_sel];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Non-ALU instructions go straight to DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = is_alu_in ? ISSUE : DONE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (wcnt == 3'd0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; strobes can only fire in ISSUE and the
    // captured opcode selects exactly one of them.
    always_comb begin
        ins_ready = (state == IDLE);
        add       = (state == ISSUE) && (op_q == OP_ADD);
        sub       = (state == ISSUE) && (op_q == OP_SUB);
        inc       = (state == ISSUE) && (op_q == OP_INC);
        dec       = (state == ISSUE) && (op_q == OP_DEC);
        done      = (state == DONE);
        err       = (state == DONE) && err_q;
    end

    // Datapath: operand capture, register-file writes, wait counter and
    // flag writeback. Reset clears everything, which also discards any ALU
    // result still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
            op_q    <= OP_NOP;
            rd_q    <= 2'd0;
            wcnt    <= 3'd0;
            err_q   <= 1'b0;
            input_x <= 8'h00;
            input_y <= 8'h00;
            flag_c  <= 1'b0;
            flag_a  <= 1'b0;
            flag_z  <= 1'b0;
            flag_s  <= 1'b0;
            flag_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        err_q <= (op_in == OP_ILL);
                        op_q  <= op_in;
                        rd_q  <= rd_in;
                        case (op_in)
                            OP_ADD, OP_SUB: begin
                                input_x <= regs[rd_in];
                                input_y <= regs[rs_in];
                            end
                            OP_INC, OP_DEC: begin
                                input_x <= regs[rd_in];
                                input_y <= 8'h00;
                            end
                            OP_MOV: regs[rd_in] <= regs[rs_in];
                            OP_LDI: regs[rd_in] <= imm_in;
                            default: ;
                        endcase
                    end
                end
                ISSUE: begin
                    wcnt <= 3'(ALU_LAT - 1);
                end
                WAIT: begin
                    if (wcnt == 3'd0) begin
                        regs[rd_q] <= alu_b;
                        flag_c     <= CF;
                        flag_a     <= AF;
                        flag_z     <= ZF;
                        flag_s     <= SF;
                        flag_o     <= OF;
                    end else begin
                        wcnt <= wcnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
